// File: rtl/pll_reconfig_pkg.sv
// Shared state encoding, divider profiles and select-pin encoding for the
// Gowin rPLL dynamic reconfiguration sequencer.
package pll_reconfig_pkg;

  typedef enum logic [2:0] {
    ST_RST_ASSERT,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RUN,
    ST_DRAIN,
    ST_FAULT
  } pll_state_t;

  typedef struct packed {
    logic [5:0] idiv;
    logic [5:0] fbdiv;
    logic [5:0] odiv;
  } pll_profile_t;

  localparam int NUM_PROFILES = 4;

  // All entries keep the VCO at 800 MHz from the 100 MHz reference.
  localparam pll_profile_t PROFILE_TABLE [NUM_PROFILES] = '{
    '{idiv: 6'd0, fbdiv: 6'd1, odiv: 6'd4},
    '{idiv: 6'd0, fbdiv: 6'd0, odiv: 6'd8},
    '{idiv: 6'd1, fbdiv: 6'd0, odiv: 6'd16},
    '{idiv: 6'd3, fbdiv: 6'd0, odiv: 6'd32}
  };

  // The rPLL dynamic select pins take the inverse of the static select value.
  function automatic logic [5:0] enc_sel(input logic [5:0] sel);
    return ~sel;
  endfunction

endpackage

// File: rtl/pll_reconfig_ctrl_lock_sync.sv
// Two-flop synchronizer bringing the asynchronous rPLL LOCK into the clkin domain.
module lock_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic sync_p0;
  logic sync_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// rPLL reset/profile sequencer with lock qualification and runtime profile changes.
// Define PLL_RECONFIG_TIMEOUT_EN to add lock timeout, retries, FAULT state and err.
module pll_reconfig_ctrl
  import pll_reconfig_pkg::*;
#(
  parameter int DEFAULT_PROFILE     = 0,
  parameter int RESET_PULSE_CYCLES  = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 3,
  parameter int DRAIN_CYCLES        = 8
) (
  input  logic       clkin,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [1:0] req_profile,
  output logic       req_ready,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [5:0] pll_idsel,
  output logic [5:0] pll_fbdsel,
  output logic [5:0] pll_odsel,
  output logic       clk_ready,
  output logic       busy,
  output logic [1:0] cur_profile,
  output logic       err
);

  localparam int CNT_MAX_A = (RESET_PULSE_CYCLES > DRAIN_CYCLES) ? RESET_PULSE_CYCLES : DRAIN_CYCLES;
  localparam int CNT_MAX   = (CNT_MAX_A > LOCK_STABLE_CYCLES) ? CNT_MAX_A : LOCK_STABLE_CYCLES;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [1:0]       DEF_PROF    = 2'(DEFAULT_PROFILE);
  localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(RESET_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_CYCLES - 1);

  if (RESET_PULSE_CYCLES < 1 || LOCK_STABLE_CYCLES < 1 || DRAIN_CYCLES < 1 ||
      LOCK_TIMEOUT_CYCLES < 1 || MAX_RETRIES < 0 ||
      DEFAULT_PROFILE < 0 || DEFAULT_PROFILE >= NUM_PROFILES) begin : g_param_check
    $error("pll_reconfig_ctrl: illegal parameter value");
  end

  pll_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       target_q, target_d;
  logic [1:0]       cur_q, cur_d;
  logic [5:0]       idsel_q, idsel_d;
  logic [5:0]       fbdsel_q, fbdsel_d;
  logic [5:0]       odsel_q, odsel_d;
  logic             pll_reset_q, pll_reset_d;
  logic             clk_ready_q, clk_ready_d;
  logic             req_ready_q, req_ready_d;
  logic             busy_q, busy_d;
  logic             lock_s;
  logic             accept;

`ifdef PLL_RECONFIG_TIMEOUT_EN
  localparam int              TO_W    = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam int              RT_W    = $clog2(MAX_RETRIES + 2);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RT_W-1:0] RT_MAX  = RT_W'(MAX_RETRIES);

  logic [TO_W-1:0] to_q, to_d;
  logic [RT_W-1:0] retries_q, retries_d;
  logic            err_q, err_d;
`endif

  lock_sync u_lock_sync (
    .clk   (clkin),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  assign accept = req_valid & req_ready_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    target_d = target_q;
    cur_d    = cur_q;
    idsel_d  = idsel_q;
    fbdsel_d = fbdsel_q;
    odsel_d  = odsel_q;
`ifdef PLL_RECONFIG_TIMEOUT_EN
    to_d      = '0;
    retries_d = retries_q;
`endif

    case (state_q)
      ST_RST_ASSERT: begin
        // Selects move only in the first reset cycle, with pll_reset already high.
        if (cnt_q == '0) begin
          idsel_d  = enc_sel(PROFILE_TABLE[target_q].idiv);
          fbdsel_d = enc_sel(PROFILE_TABLE[target_q].fbdiv);
          odsel_d  = enc_sel(PROFILE_TABLE[target_q].odiv);
          cur_d    = target_q;
        end
        if (cnt_q == PULSE_LAST) state_d = ST_WAIT_LOCK;
        else                     cnt_d   = cnt_q + 1'b1;
      end

      ST_WAIT_LOCK: begin
        if (lock_s) begin
          if (LOCK_STABLE_CYCLES == 1) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_STABLE;
            cnt_d   = CNT_W'(1);
          end
        end
`ifdef PLL_RECONFIG_TIMEOUT_EN
        else if (to_q == TO_LAST) begin
          if (retries_q < RT_MAX) begin
            retries_d = retries_q + 1'b1;
            state_d   = ST_RST_ASSERT;
          end else begin
            state_d = ST_FAULT;
          end
        end else begin
          to_d = to_q + 1'b1;
        end
`endif
      end

      ST_STABLE: begin
        if (!lock_s)                   state_d = ST_WAIT_LOCK;
        else if (cnt_q == STABLE_LAST) state_d = ST_RUN;
        else                           cnt_d   = cnt_q + 1'b1;
      end

      ST_RUN: begin
        // An accepted request wins over a simultaneous lock drop: the requester saw ready.
        if (accept) begin
          target_d = req_profile;
          state_d  = ST_DRAIN;
        end else if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end
      end

      ST_DRAIN: begin
        if (cnt_q == DRAIN_LAST) state_d = ST_RST_ASSERT;
        else                     cnt_d   = cnt_q + 1'b1;
      end

`ifdef PLL_RECONFIG_TIMEOUT_EN
      ST_FAULT: begin
        if (accept) begin
          target_d  = req_profile;
          retries_d = '0;
          state_d   = ST_DRAIN;
        end
      end
`endif

      default: state_d = ST_RST_ASSERT;
    endcase

`ifdef PLL_RECONFIG_TIMEOUT_EN
    if (state_d == ST_RUN) retries_d = '0;
    err_d = err_q | (state_d == ST_FAULT);
`endif

    // Outputs are registered from the next state so they align with it.
    pll_reset_d = (state_d == ST_RST_ASSERT) || (state_d == ST_FAULT);
    clk_ready_d = (state_d == ST_RUN);
    req_ready_d = (state_d == ST_RUN) || (state_d == ST_FAULT);
    busy_d      = !req_ready_d;
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RST_ASSERT;
      cnt_q       <= '0;
      target_q    <= DEF_PROF;
      cur_q       <= DEF_PROF;
      idsel_q     <= enc_sel(PROFILE_TABLE[DEF_PROF].idiv);
      fbdsel_q    <= enc_sel(PROFILE_TABLE[DEF_PROF].fbdiv);
      odsel_q     <= enc_sel(PROFILE_TABLE[DEF_PROF].odiv);
      pll_reset_q <= 1'b1;
      clk_ready_q <= 1'b0;
      req_ready_q <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      target_q    <= target_d;
      cur_q       <= cur_d;
      idsel_q     <= idsel_d;
      fbdsel_q    <= fbdsel_d;
      odsel_q     <= odsel_d;
      pll_reset_q <= pll_reset_d;
      clk_ready_q <= clk_ready_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
    end
  end

`ifdef PLL_RECONFIG_TIMEOUT_EN
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      to_q      <= '0;
      retries_q <= '0;
      err_q     <= 1'b0;
    end else begin
      to_q      <= to_d;
      retries_q <= retries_d;
      err_q     <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign pll_reset   = pll_reset_q;
  assign pll_idsel   = idsel_q;
  assign pll_fbdsel  = fbdsel_q;
  assign pll_odsel   = odsel_q;
  assign clk_ready   = clk_ready_q;
  assign req_ready   = req_ready_q;
  assign busy        = busy_q;
  assign cur_profile = cur_q;

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Directed-plus-random bench for pll_reconfig_ctrl; the fault scenario runs when
// PLL_RECONFIG_TIMEOUT_EN is defined.
module tb_pll_reconfig_ctrl;

  localparam int RP       = 4;
  localparam int LS       = 8;
  localparam int LT       = 32;
  localparam int MR       = 2;
  localparam int DC       = 3;
  localparam int SYNC_LAT = 2;
  localparam int BOUND    = 200;

  logic       clkin = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [1:0] req_profile = 2'd0;
  logic       pll_lock = 1'b0;
  logic       req_ready;
  logic       pll_reset;
  logic [5:0] pll_idsel;
  logic [5:0] pll_fbdsel;
  logic [5:0] pll_odsel;
  logic       clk_ready;
  logic       busy;
  logic [1:0] cur_profile;
  logic       err;

  int checks = 0;
  int errors = 0;

  // Reference divider values per profile (IDIV / FBDIV / ODIV).
  int div_i [4] = '{0, 0, 1, 3};
  int div_f [4] = '{1, 0, 0, 0};
  int div_o [4] = '{4, 8, 16, 32};

  always #5 clkin = ~clkin;

  pll_reconfig_ctrl #(
    .DEFAULT_PROFILE     (0),
    .RESET_PULSE_CYCLES  (RP),
    .LOCK_STABLE_CYCLES  (LS),
    .LOCK_TIMEOUT_CYCLES (LT),
    .MAX_RETRIES         (MR),
    .DRAIN_CYCLES        (DC)
  ) dut (
    .clkin       (clkin),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_profile (req_profile),
    .req_ready   (req_ready),
    .pll_lock    (pll_lock),
    .pll_reset   (pll_reset),
    .pll_idsel   (pll_idsel),
    .pll_fbdsel  (pll_fbdsel),
    .pll_odsel   (pll_odsel),
    .clk_ready   (clk_ready),
    .busy        (busy),
    .cur_profile (cur_profile),
    .err         (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  function automatic logic [5:0] pin(input int v);
    logic [5:0] s;
    s = 6'(v);
    return ~s;
  endfunction

  task automatic check_sels(input string tag, input int p);
    check({tag, "_idsel"},  {26'd0, pll_idsel},  {26'd0, pin(div_i[p])});
    check({tag, "_fbdsel"}, {26'd0, pll_fbdsel}, {26'd0, pin(div_f[p])});
    check({tag, "_odsel"},  {26'd0, pll_odsel},  {26'd0, pin(div_o[p])});
    check({tag, "_cur"},    {30'd0, cur_profile}, p);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pll_reset"}, {31'd0, pll_reset}, 1);
    check({tag, "_clk_ready"}, {31'd0, clk_ready}, 0);
    check({tag, "_req_ready"}, {31'd0, req_ready}, 0);
    check({tag, "_busy"},      {31'd0, busy}, 1);
    check({tag, "_err"},       {31'd0, err}, 0);
    check_sels(tag, 0);
  endtask

  // Ticks until pll_reset reaches level; -1 if the bound expires.
  task automatic count_reset(input logic level, output int n);
    n = 0;
    while (pll_reset !== level) begin
      tick();
      n++;
      if (n > BOUND) begin
        n = -1;
        break;
      end
    end
  endtask

  task automatic count_ready(input logic level, output int n, output bit rst_seen);
    n = 0;
    rst_seen = 1'b0;
    while (clk_ready !== level) begin
      tick();
      n++;
      if (pll_reset !== 1'b0) rst_seen = 1'b1;
      if (n > BOUND) begin
        n = -1;
        break;
      end
    end
  endtask

  // Entered with pll_reset just seen high; the modelled PLL relocks dly cycles after reset falls.
  task automatic bring_up(input string tag, input int p, input int dly, input int glitch_at);
    int n;
    bit rs;
    pll_lock = 1'b0;
    count_reset(1'b0, n);
    check({tag, "_pulse_len"}, n, RP);
    check_sels(tag, p);
    repeat (dly) tick();
    pll_lock = 1'b1;
    if (glitch_at > 0) begin
      repeat (glitch_at) tick();
      check({tag, "_ready_before_glitch"}, {31'd0, clk_ready}, 0);
      pll_lock = 1'b0;
      repeat (2) tick();
      pll_lock = 1'b1;
    end
    count_ready(1'b1, n, rs);
    check({tag, "_ready_latency"}, n, SYNC_LAT + LS);
    check({tag, "_reset_quiet"}, {31'd0, rs}, 0);
    check({tag, "_run_busy"}, {31'd0, busy}, 0);
    check({tag, "_run_req_ready"}, {31'd0, req_ready}, 1);
  endtask

  // Issues a request in RUN/FAULT and returns once pll_reset has risen.
  task automatic request(input string tag, input int p);
    int n;
    req_valid   = 1'b1;
    req_profile = 2'(p);
    tick();
    req_valid = 1'b0;
    check({tag, "_acc_req_ready"}, {31'd0, req_ready}, 0);
    check({tag, "_acc_clk_ready"}, {31'd0, clk_ready}, 0);
    check({tag, "_acc_busy"},      {31'd0, busy}, 1);
    count_reset(1'b1, n);
    check({tag, "_drain_len"}, n, DC);
  endtask

  initial begin
    int n;
    int p;
    bit rs;

    // Reset state
    repeat (2) tick();
    check_reset_values("rst");

    // Power-up
    rst_n = 1'b1;
    bring_up("pwr", 0, 10, 0);

    // Reconfiguration to profile 3 with a lock glitch while stabilising
    request("rcf3", 3);
    bring_up("rcf3", 3, $urandom_range(2, 12), $urandom_range(2, 6));

    // Lock loss in RUN
    repeat ($urandom_range(1, 5)) tick();
    pll_lock = 1'b0;
    count_ready(1'b0, n, rs);
    check("loss_drop_latency", n, SYNC_LAT + 1);
    repeat ($urandom_range(2, 10)) begin
      tick();
      if (pll_reset !== 1'b0) rs = 1'b1;
    end
    check("loss_reset_quiet", {31'd0, rs}, 0);
    check("loss_busy", {31'd0, busy}, 1);
    pll_lock = 1'b1;
    count_ready(1'b1, n, rs);
    check("loss_relock_latency", n, SYNC_LAT + LS);
    check("loss_relock_reset_quiet", {31'd0, rs}, 0);

    // Random reconfigurations, same-profile requests included
    repeat (4) begin
      p = $urandom_range(0, 3);
      request("rnd", p);
      bring_up("rnd", p, $urandom_range(1, 15), 0);
    end

`ifdef PLL_RECONFIG_TIMEOUT_EN
    // Persistent failure: lock never comes back
    p = $urandom_range(0, 3);
    request("flt", p);
    pll_lock = 1'b0;
    for (int a = 0; a <= MR; a++) begin
      count_reset(1'b0, n);
      check("flt_pulse_len", n, RP);
      check_sels("flt", p);
      count_reset(1'b1, n);
      check("flt_wait_len", n, LT);
      if (a < MR) check("flt_err_early", {31'd0, err}, 0);
    end
    check("flt_err", {31'd0, err}, 1);
    check("flt_req_ready", {31'd0, req_ready}, 1);
    check("flt_busy", {31'd0, busy}, 0);
    check("flt_clk_ready", {31'd0, clk_ready}, 0);
    repeat (3 * RP) tick();
    check("flt_reset_held", {31'd0, pll_reset}, 1);
    check("flt_err_held", {31'd0, err}, 1);
    request("flt_rec", 1);
    bring_up("flt_rec", 1, $urandom_range(1, 15), 0);
    check("flt_rec_err_sticky", {31'd0, err}, 1);
`endif

    // Async reset in the middle of DRAIN
    p = $urandom_range(1, 3);
    request("pre", p);
    bring_up("pre", p, $urandom_range(1, 15), 0);
    req_valid   = 1'b1;
    req_profile = 2'($urandom_range(0, 3));
    tick();
    req_valid = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("arst");
    pll_lock = 1'b0;
    tick();
    rst_n = 1'b1;
    bring_up("arst", 0, $urandom_range(1, 15), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pll_reconfig_ctrl.md
# pll_reconfig_ctrl

Sequencer for the Gowin rPLL's dynamic divider inputs. It holds the PLL in reset, loads one of four frequency profiles onto IDSEL/FBDSEL/ODSEL, and qualifies LOCK with a stability window. Only after that does it release `clk_ready` to downstream clock-domain logic. It runs on the PLL reference clock (100 MHz) and accepts runtime profile-change requests through a valid/ready handshake.

## Interface
- `DEFAULT_PROFILE`, 0: profile loaded out of reset.
- `RESET_PULSE_CYCLES`, 16: cycles `pll_reset` is held high per attempt.
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronized-lock cycles required before `clk_ready`.
- `LOCK_TIMEOUT_CYCLES`, 65536: WAIT_LOCK budget per attempt.
- `MAX_RETRIES`, 3: re-reset attempts after a timeout before FAULT.
- `DRAIN_CYCLES`, 8: cycles `clk_ready` is low before the PLL is reset on reconfiguration.
- `clkin`, in, 1: reference clock; all logic is in this domain.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req_valid`, in, 1: profile-change request.
- `req_profile`, in, 2: requested profile index.
- `req_ready`, out, 1: request accepted when `req_valid & req_ready`.
- `pll_lock`, in, 1: rPLL LOCK. It is asynchronous and is synchronized internally.
- `pll_reset`, out, 1: drives rPLL RESET.
- `pll_idsel`, `pll_fbdsel`, `pll_odsel`, out, 6 each: dynamic divider selects.
- `clk_ready`, out, 1: PLL output is qualified.
- `busy`, out, 1: not in RUN or FAULT.
- `cur_profile`, out, 2: profile currently applied.
- `err`, out, 1: sticky lock-timeout fault.

## Operation
- **Pin encoding.** Each select pin value is the bitwise inverse of the static select (`~IDIV_SEL`, etc.).
- **Profiles.** Each entry is IDIV/FBDIV/ODIV, and all use VCO = 800 MHz.
  - 0 = 200 MHz (0/1/4)
  - 1 = 100 MHz (0/0/8)
  - 2 = 50 MHz (1/0/16)
  - 3 = 25 MHz (3/0/32)
- **Reset values.** `pll_reset`=1, selects = DEFAULT_PROFILE encoding, `cur_profile`=DEFAULT_PROFILE, `clk_ready`=0, `req_ready`=0, `busy`=1, `err`=0. State = RST_ASSERT, all counters 0.
- **States.**
  - **RST_ASSERT:** `pll_reset`=1. Selects load from the latched target profile on the first cycle; `cur_profile` updates at the same time. After RESET_PULSE_CYCLES → WAIT_LOCK.
  - **WAIT_LOCK:** `pll_reset`=0, timeout counter runs. Synchronized lock = 1 → STABLE. Timeout with retries < MAX_RETRIES → retries+1, RST_ASSERT. Otherwise → FAULT.
  - **STABLE:** counts consecutive lock cycles. Lock drop → WAIT_LOCK, with the stability counter cleared and the timeout counter restarted. Count reaching LOCK_STABLE_CYCLES → RUN, and retries clear.
  - **RUN:** `clk_ready`=1, `req_ready`=1. Lock loss → `clk_ready`=0 and → WAIT_LOCK; the PLL is not reset. An accepted request latches `req_profile` → DRAIN.
  - **DRAIN:** `clk_ready`=0. After DRAIN_CYCLES → RST_ASSERT.
  - **FAULT:** `pll_reset`=1, `err`=1, `req_ready`=1. An accepted request clears retries and → DRAIN with the new target; `err` stays set.
- **Same-profile requests.** A request for the current profile still performs the full reconfiguration sequence.
- **Mid-operation reset.** `rst_n` assertion mid-sequence returns everything to reset values immediately.

## Timing
- `pll_lock` passes through a 2-FF synchronizer, so there are 2 cycles of latency before the FSM sees it.
- Accept handshake:
  - Cycle after the accept: `req_ready`=0, `clk_ready`=0, `busy`=1.
  - `pll_reset` rises DRAIN_CYCLES cycles after the accept.
- `clk_ready` rises the cycle after the LOCK_STABLE_CYCLES-th consecutive synchronized-high cycle.
- Selects change only while `pll_reset`=1, and are held constant at all other times.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `PLL_RECONFIG_TIMEOUT_EN` defined: the timeout counter, retry logic, FAULT state and `err` are all present.
- Undefined: WAIT_LOCK waits indefinitely, `err` is tied 0, FAULT is unreachable, and the timeout and retry counters are removed.

## Structure
- Package `pll_reconfig_pkg` holds:
  - state enum
  - `pll_profile_t` struct (idiv/fbdiv/odiv, 6 b each)
  - 4-entry `PROFILE_TABLE` constant
  - `enc_sel()` inversion function
- Sub-module `lock_sync`: 2-FF synchronizer with asynchronous active-low reset, reset value 0.

## Test plan
Bench parameters are RESET_PULSE_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2, DRAIN_CYCLES=3.
- **Power-up:** release `rst_n`; lock model asserts 10 cycles after `pll_reset` falls → `pll_reset` high for 4 cycles; selects = ~0/~1/~4; `clk_ready` rises 8 cycles after synchronized lock; `cur_profile`=0.
- **Reconfiguration:** in RUN, request profile 3 → `clk_ready` low the next cycle; `pll_reset` rises 3 cycles after the accept; selects = ~3/~0/~32; `clk_ready` returns; `cur_profile`=3.
- **Lock glitch:** lock drops for 2 cycles during STABLE → stability count restarts; `clk_ready` delayed by the full 8 cycles after lock returns.
- **Lock loss in RUN:** lock drops → `clk_ready`=0 within 3 cycles and `pll_reset` stays 0; lock returns → `clk_ready` after 8 cycles.
- **Persistent failure (macro defined):** lock never asserts → 3 reset pulses, then FAULT with `err`=1, `pll_reset`=1, `req_ready`=1. Request profile 1 with lock working → RUN and `err` still 1.
- **Async reset:** `rst_n` pulsed low mid-DRAIN → all outputs at reset values immediately; sequence restarts with profile 0.
